// File: rtl/codec_dac_i2s_tx.sv
// -----------------------------------------------------------------------------
// codec_dac_i2s_tx
//
// I2S master transmitter for the WM8731 DAC path. A stereo sample pair is taken
// from the register side through a valid/ready handshake and held in a
// one-entry buffer. The block divides the system clock down to BCLK, generates
// DACLRC and shifts both channels out MSB first on DACDAT. The data is delayed
// by one BCLK after each LRC edge, as I2S requires.
//
// Ports
//   clk       system clock (50 MHz)
//   rst_n     asynchronous active-low reset
//   enable    1 = run BCLK/LRC/serialiser, 0 = hold the codec lines idle
//   s_valid   sample pair valid
//   s_ready   buffer can accept a pair (combinational, = !buffer full)
//   s_left    left sample, two's complement, DATA_W bits
//   s_right   right sample, two's complement, DATA_W bits
//   dac_bclk  bit clock to codec BCLK
//   dac_lrc   DACLRC, 0 = left slot, 1 = right slot
//   dac_dat   DACDAT serial data
//   underrun  one-clk pulse when a frame starts with the buffer empty
//
// Parameters
//   DATA_W     sample width per channel
//   SLOT_BITS  BCLK periods per channel slot, must be >= DATA_W+1
//   BCLK_DIV   clk cycles per BCLK half period
// -----------------------------------------------------------------------------
module codec_dac_i2s_tx #(
  parameter int DATA_W    = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              dac_bclk,
  output logic              dac_lrc,
  output logic              dac_dat,
  output logic              underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  // One-entry sample buffer
  logic              buf_full_reg,  buf_full_next;
  logic [DATA_W-1:0] buf_left_reg,  buf_left_next;
  logic [DATA_W-1:0] buf_right_reg, buf_right_next;

  // Clock divider and frame position
  logic [DIV_W-1:0]  div_cnt_reg,   div_cnt_next;
  logic [CNT_W-1:0]  bit_cnt_reg,   bit_cnt_next;

  // Serialiser and registered outputs
  logic [DATA_W-1:0] sh_left_reg,   sh_left_next;
  logic [DATA_W-1:0] sh_right_reg,  sh_right_next;
  logic              bclk_reg,      bclk_next;
  logic              lrc_reg,       lrc_next;
  logic              dat_reg,       dat_next;
  logic              underrun_reg,  underrun_next;

  // Event decode
  logic              div_tc;
  logic              fall_evt;
  logic              frame_start;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic              in_right;
  logic [CNT_W-1:0]  slot_pos;
  logic              data_bit;

  assign div_tc   = (div_cnt_reg == DIV_LAST);
  // A fall event is the cycle in which BCLK goes 1->0; every data/LRC change
  // happens here so DACDAT is stable around the codec's rising-edge sample.
  assign fall_evt = enable && div_tc && bclk_reg;

  // Everything below is evaluated on the bit counter value being entered.
  assign bit_cnt_inc = (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CNT_W'(1);
  assign frame_start = fall_evt && (bit_cnt_inc == '0);
  assign in_right    = (bit_cnt_inc >= SLOT_LEN);
  assign slot_pos    = in_right ? (bit_cnt_inc - SLOT_LEN) : bit_cnt_inc;
  // Position 0 is the I2S one-bit delay slot; positions past DATA_W are padding.
  assign data_bit    = (slot_pos != '0) && (slot_pos <= DATA_LEN);

  always_comb begin
    buf_full_next  = buf_full_reg;
    buf_left_next  = buf_left_reg;
    buf_right_next = buf_right_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    sh_left_next   = sh_left_reg;
    sh_right_next  = sh_right_reg;
    bclk_next      = bclk_reg;
    lrc_next       = lrc_reg;
    dat_next       = dat_reg;
    underrun_next  = 1'b0;

    if (!enable) begin
      // Idle: park the lines and rewind so the next enable starts a fresh
      // frame. The shift registers are reloaded at that frame start anyway.
      div_cnt_next = '0;
      bit_cnt_next = LAST_BIT;
      bclk_next    = 1'b0;
      lrc_next     = 1'b0;
      dat_next     = 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt_next = '0;
        bclk_next    = !bclk_reg;
      end else begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
      end

      if (fall_evt) begin
        bit_cnt_next = bit_cnt_inc;
        lrc_next     = in_right;
        dat_next     = 1'b0;
        if (frame_start) begin
          if (buf_full_reg) begin
            sh_left_next  = buf_left_reg;
            sh_right_next = buf_right_reg;
          end else begin
            // Nothing queued: send a silent frame and flag it.
            sh_left_next  = '0;
            sh_right_next = '0;
            underrun_next = 1'b1;
          end
        end else if (data_bit) begin
          if (in_right) begin
            dat_next      = sh_right_reg[DATA_W-1];
            sh_right_next = {sh_right_reg[DATA_W-2:0], 1'b0};
          end else begin
            dat_next      = sh_left_reg[DATA_W-1];
            sh_left_next  = {sh_left_reg[DATA_W-2:0], 1'b0};
          end
        end
      end
    end

    // The buffer runs regardless of enable. A full buffer drained at frame
    // start cannot also accept in that cycle because s_ready is low; an empty
    // buffer can accept during an underrun frame start, and that pair then
    // waits for the following frame.
    if (frame_start && buf_full_reg) begin
      buf_full_next = 1'b0;
    end else if (s_valid && !buf_full_reg) begin
      buf_full_next  = 1'b1;
      buf_left_next  = s_left;
      buf_right_next = s_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_reg  <= 1'b0;
      buf_left_reg  <= '0;
      buf_right_reg <= '0;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= LAST_BIT;
      sh_left_reg   <= '0;
      sh_right_reg  <= '0;
      bclk_reg      <= 1'b0;
      lrc_reg       <= 1'b0;
      dat_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      buf_full_reg  <= buf_full_next;
      buf_left_reg  <= buf_left_next;
      buf_right_reg <= buf_right_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      sh_left_reg   <= sh_left_next;
      sh_right_reg  <= sh_right_next;
      bclk_reg      <= bclk_next;
      lrc_reg       <= lrc_next;
      dat_reg       <= dat_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign s_ready  = !buf_full_reg;
  assign dac_bclk = bclk_reg;
  assign dac_lrc  = lrc_reg;
  assign dac_dat  = dat_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_codec_dac_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_codec_dac_i2s_tx
//
// Bench for the I2S DAC transmitter. A negedge monitor models the codec: it
// decodes whole frames from BCLK/LRC/DAT. It also models the one-entry sample
// buffer, so it knows which pair (or silence) each frame must carry and when
// underrun must pulse. Expected frames are queued at frame start and popped
// when the frame has been fully received. A table of sample pairs with
// hand-computed slot images is streamed back-to-back. Hand-written sequences
// cover startup latency, underrun, back-pressure, abort and reset.
// -----------------------------------------------------------------------------
module tb_codec_dac_i2s_tx;

  localparam int DATA_W    = 24;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_DIV  = 8;
  localparam int FRAME_CLK = 2 * SLOT_BITS * 2 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        s_ready;
  logic        dac_bclk;
  logic        dac_lrc;
  logic        dac_dat;
  logic        underrun;

  codec_dac_i2s_tx #(.DATA_W(DATA_W), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .dac_bclk(dac_bclk), .dac_lrc(dac_lrc), .dac_dat(dac_dat), .underrun(underrun)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_ls;   // left slot as seen on DACDAT, first bit in MSB
    logic [31:0] exp_rs;
  } vec_t;

  typedef struct {
    logic [63:0] frame;
    bit          data;
  } exp_t;

  vec_t        tbl [5];
  exp_t        exp_q [$];
  logic [63:0] dec_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // ---------------- monitor: codec model + buffer model ----------------
  bit          prev_bclk = 1'b0;
  bit          prev_lrc = 1'b0;
  bit          first = 1'b1;
  bit          mb_full = 1'b0;
  logic [23:0] mb_l = '0;
  logic [23:0] mb_r = '0;
  int          fpos = -1;
  logic [63:0] fbits = '0;
  longint      cyc = 0;
  longint      last_rise = -1;
  longint      last_lrc = -1;
  int          data_frames = 0;
  int          urun_seen = 0;
  bit          m_fall, m_rise, m_fs, m_acc, m_urun;
  exp_t        m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_lines", 64'({dac_bclk, dac_lrc, dac_dat, underrun, !s_ready}), 64'd0);
      mb_full   = 1'b0;
      exp_q.delete();
      first     = 1'b1;
      fpos      = -1;
      last_rise = -1;
      last_lrc  = -1;
    end else begin
      if (underrun) urun_seen++;
      m_acc = s_valid && !mb_full;
      if (!enable) begin
        check("idle_lines", 64'({dac_bclk, dac_lrc, dac_dat, underrun}), 64'd0);
        first     = 1'b1;
        fpos      = -1;
        exp_q.delete();
        last_rise = -1;
        last_lrc  = -1;
      end else begin
        m_fall = prev_bclk && !dac_bclk;
        m_rise = !prev_bclk && dac_bclk;
        m_fs   = m_fall && !dac_lrc && (prev_lrc || first);
        m_urun = m_fs && !mb_full;
        if (underrun || m_urun) check("underrun", 64'(underrun), 64'(m_urun));
        if (m_fs) begin
          if (exp_q.size() != 0) begin
            check("frame_overlap", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
          end
          m_e.frame = mb_full ? frame_of(mb_l, mb_r) : 64'd0;
          m_e.data  = mb_full;
          exp_q.push_back(m_e);
          mb_full = 1'b0;
          first   = 1'b0;
          fpos    = 0;
        end
        if (m_rise) begin
          if (last_rise >= 0) check("bclk_period", 64'(cyc - last_rise), 64'(2 * BCLK_DIV));
          last_rise = cyc;
          if (fpos >= 0) begin
            fbits[63 - fpos] = dac_dat;
            fpos++;
            if (fpos == 64) begin
              dec_q.push_back(fbits);
              m_e = exp_q.pop_front();
              check("frame", fbits, m_e.frame);
              if (m_e.data) data_frames++;
              fpos = -1;
            end
          end
        end
        if (dac_lrc != prev_lrc) begin
          if (last_lrc >= 0) check("lrc_half_period", 64'(cyc - last_lrc), 64'(SLOT_BITS * 2 * BCLK_DIV));
          last_lrc = cyc;
        end
      end
      if (m_acc) begin
        mb_full = 1'b1;
        mb_l    = s_left;
        mb_r    = s_right;
      end
      check("s_ready", 64'(s_ready), 64'(!mb_full));
    end
    prev_bclk = dac_bclk;
    prev_lrc  = dac_lrc;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called at negedge+1; holds s_valid until the pair has been taken.
  task automatic send(input logic [23:0] l, input logic [23:0] r, output int waited);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    waited  = 0;
    while (!s_ready && waited < 3000) begin
      tick();
      waited++;
    end
    check("send_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // Called right after enable is raised; measures cycles to first events.
  task automatic measure_startup(input string tag);
    int rise_c = -1;
    int fall_c = -1;
    int msb_c  = -1;
    bit pb = 1'b0;
    bit lrc_at_fall = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dac_bclk && rise_c < 0) rise_c = c;
      if (pb && !dac_bclk && fall_c < 0) begin
        fall_c = c;
        lrc_at_fall = dac_lrc;
      end
      if (dac_dat && msb_c < 0) msb_c = c;
      pb = dac_bclk;
    end
    check({tag, "_first_rise"}, 64'(rise_c), 64'(BCLK_DIV));
    check({tag, "_first_fall"}, 64'(fall_c), 64'(2 * BCLK_DIV));
    check({tag, "_lrc_at_start"}, 64'(lrc_at_fall), 64'd0);
    check({tag, "_left_msb"}, 64'(msb_c), 64'(4 * BCLK_DIV));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int df0;
    int ur0;
    logic [63:0] act;

    tbl[0] = '{l: 24'h842124, r: 24'h7FFFFF, exp_ls: 32'h42109200, exp_rs: 32'h3FFFFF80};
    tbl[1] = '{l: 24'h000001, r: 24'h800000, exp_ls: 32'h00000080, exp_rs: 32'h40000000};
    tbl[2] = '{l: 24'hFFFFFF, r: 24'h000000, exp_ls: 32'h7FFFFF80, exp_rs: 32'h00000000};
    tbl[3] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, exp_ls: 32'h52D2D280, exp_rs: 32'h2D2D2D00};
    tbl[4] = '{l: 24'h800001, r: 24'h00FFFF, exp_ls: 32'h40000080, exp_rs: 32'h007FFF80};

    // Reset, then idle with enable low.
    repeat (3) tick();
    check("rst_outputs", 64'({dac_bclk, dac_lrc, dac_dat, underrun}), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    repeat (100) tick();
    check("idle_100", 64'({dac_bclk, dac_lrc, dac_dat, underrun}), 64'd0);

    // Table: first pair buffered before enable, rest streamed back-to-back.
    dec_q.delete();
    df0 = data_frames;
    send(tbl[0].l, tbl[0].r, w);
    enable = 1'b1;
    measure_startup("start");
    for (int i = 1; i < 5; i++) send(tbl[i].l, tbl[i].r, w);
    repeat (3 * FRAME_CLK) tick();
    enable = 1'b0;
    tick();
    check("table_frames", 64'(data_frames - df0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      act = (i < dec_q.size()) ? dec_q[i] : 64'bx;
      check($sformatf("vec%0d", i), act, {tbl[i].exp_ls, tbl[i].exp_rs});
    end

    // Underrun: start with empty buffer, then queue one pair.
    df0 = data_frames;
    ur0 = urun_seen;
    enable = 1'b1;
    repeat (40) tick();
    send(24'h123456, 24'hABCDEF, w);
    repeat (2 * FRAME_CLK + 200) tick();
    enable = 1'b0;
    tick();
    check("underrun_data_frames", 64'(data_frames - df0), 64'd1);
    check("underrun_pulses", 64'(urun_seen - ur0), 64'd2);

    // Back-pressure: second pair waits for the next frame start.
    df0 = data_frames;
    enable = 1'b1;
    repeat (40) tick();
    send(24'h111111, 24'h222222, w);
    send(24'h333333, 24'h444444, w);
    check("bp_waited", 64'(w > 900), 64'd1);
    repeat (3 * FRAME_CLK) tick();
    enable = 1'b0;
    tick();
    check("bp_data_frames", 64'(data_frames - df0), 64'd2);

    // Abort at bit_cnt 40 with a pair still buffered, then restart.
    df0 = data_frames;
    send(24'h0F0F0F, 24'hF0F0F0, w);
    enable = 1'b1;
    repeat (20) tick();
    send(24'hC0FFEE, 24'h654321, w);
    repeat (636) tick();
    enable = 1'b0;
    tick();
    check("abort_lines", 64'({dac_bclk, dac_lrc, dac_dat}), 64'd0);
    repeat (5) tick();
    check("abort_buffer_kept", 64'(s_ready), 64'd0);
    enable = 1'b1;
    measure_startup("restart");
    repeat (FRAME_CLK + 100) tick();
    check("restart_data_frames", 64'(data_frames - df0), 64'd1);

    // Reset pulse mid-frame with a pending pair.
    send(24'h5A5A5A, 24'hA5A5A5, w);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_lines", 64'({dac_bclk, dac_lrc, dac_dat, underrun}), 64'd0);
    check("rst_mid_ready", 64'(s_ready), 64'd1);
    repeat (3) tick();
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (20) tick();
    check("post_rst_ready", 64'(s_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
